ingress_dispatch: RTL and testbench
===================================

// Module: ingress_dispatch
// PURPOSE
//  Writer side of the routing input path: accepts an 8-bit data + class stream and pushes
//  10-bit words {tag,class,data} into the two 8x10 ingress FIFOs that the router pops.
//  Steers each word round-robin (or by class), honours FIFO almost-full/full back-pressure,
//  holds one word while blocked, and counts words pushed per FIFO.
// PARAMETERS
//  CLASS_STEER  0  0: round-robin with redirect around a blocked FIFO; 1: class bit picks FIFO
//  COUNT_W      8  width of per-FIFO push counters
// PORTS
//  clk             in   1        single clock, rising edge
//  reset           in   1        asynchronous, active-low
//  valid_in        in   1        source word valid
//  data_in         in   8        source data
//  class_in        in   1        source class bit, copied to word bit 8
//  ready_out       out  1        dispatcher can accept; transfer = valid_in & ready_out
//  flush           in   1        sync discard of held word
//  almost_full0    in   1        FIFO0 almost full
//  fifo_full0      in   1        FIFO0 full
//  almost_full1    in   1        FIFO1 almost full
//  fifo_full1      in   1        FIFO1 full
//  push0           out  1        write strobe FIFO0
//  word0           out  10       FIFO0 write data
//  push1           out  1        write strobe FIFO1
//  word1           out  10       FIFO1 write data
//  pause           out  1        high while a held word is blocked
//  Error           out  1        sticky: push issued into a full FIFO
//  count0          out  COUNT_W  words pushed to FIFO0
//  count1          out  COUNT_W  words pushed to FIFO1
// BEHAVIOUR
//  - Reset (async, low): push0/1=0, word0/1=0, pause=0, Error=0, count0/1=0, rr=0, held=0,
//    state=IDLE; ready_out=1 after reset release. Reset mid-hold discards the held word.
//  - Word format: [9]=1 tag, [8]=class, [7:0]=data. Idle word0/1 keep last value.
//  - blockedK = almost_fullK | fifo_fullK, sampled in the cycle of the decision.
//  - All outputs registered. push0/1 are single-cycle strobes, never both high.
//  - FSM IDLE (ready_out=1): on transfer pick target T:
//      CLASS_STEER=0: T=rr if !blocked[rr], else ~rr if !blocked[~rr], else none.
//      CLASS_STEER=1: T=class_in if !blocked[class_in], else none.
//    T valid -> pushT=1 next cycle with the word (latency 1), stay IDLE.
//    none -> word to hold register, go PAUSE.
//  - PAUSE (ready_out=0, pause=1): re-evaluate target each cycle with same rule (class from
//    held word). When free -> push held word next cycle, go IDLE. flush=1 -> drop, go IDLE,
//    no push. flush has priority over a free target in the same cycle.
//  - rr <= ~T after every push (also when redirected). rr unused when CLASS_STEER=1.
//  - countK increments on each pushK, wraps 2^COUNT_W-1 -> 0.
//  - Error sets if pushK=1 while fifo_fullK=1 in the same cycle; cleared only by reset.
//  - Back-to-back: one word per cycle sustained while targets not blocked.
//  - blocked rising in the cycle after a push doesn't cancel that push (in flight).
// STRUCTURE
//  - routing_pkg: word field indices (TAG_BIT=9, CLASS_BIT=8, DATA_MSB=7),
//    state encodings IDLE/PAUSE, default COUNT_W.
//  - Sub-module rr_pick2: two-way picker: inputs rr, pref_class, steer_mode, blocked[1:0];
//    outputs sel, none. Combinational, shared by IDLE and PAUSE paths.
//  - Top: FSM, hold register, output registers, counters, Error flag.
// TESTING
//  1 Reset low mid-PAUSE -> all outputs 0, ready_out=1 after release, held word never pushed.
//  2 RR, no back-pressure, send 0xA1(c0),0xB2(c1),0xC3(c0) -> word0=0x2A1, word1=0x3B2,
//    word0=0x2C3 on consecutive cycles; count0=2, count1=1.
//  3 RR, almost_full0=1, send 0x11,0x22 -> both to FIFO1 (0x211,0x222); count0=0.
//  4 Both almost_full=1, send 0x55 -> pause=1, ready_out=0; drop almost_full1
//    -> push1 next cycle word1=0x255, pause=0, ready_out=1.
//  5 CLASS_STEER=1, almost_full1=1, send 0x7F(c1) -> PAUSE (no redirect); flush=1 -> IDLE,
//    no push, counts unchanged.
//  6 COUNT_W=2, 5 pushes to FIFO0 -> count0 = 1 (wrap); force fifo_full0 during a push -> Error=1.

Source files
------------

// File: rtl/routing_pkg.sv
// Shared definitions for the ingress routing path: word layout, FSM states, defaults.
package routing_pkg;

  localparam int WORD_W      = 10;
  localparam int TAG_BIT     = 9;
  localparam int CLASS_BIT   = 8;
  localparam int DATA_MSB    = 7;
  localparam int COUNT_W_DEF = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    PAUSE = 1'b1
  } state_e;

endpackage

// File: rtl/rr_pick2.sv
// Two-way FIFO picker, shared by the fresh-word and held-word paths.
module rr_pick2
  import routing_pkg::*;
(
  input  logic       rr,
  input  logic       pref_class,
  input  logic       steer_mode,
  input  logic [1:0] blocked,
  output logic       sel,
  output logic       none
);

  // Round-robin with redirect, or strict class steering with no redirect.
  always_comb begin
    sel  = rr;
    none = 1'b0;
    if (steer_mode) begin
      sel  = pref_class;
      none = blocked[pref_class];
    end else if (!blocked[rr]) begin
      sel = rr;
    end else if (!blocked[!rr]) begin
      sel = !rr;
    end else begin
      none = 1'b1;
    end
  end

endmodule

// File: rtl/ingress_dispatch.sv
// Writer side of the router input path: steers tagged words into two ingress FIFOs.
//
// state | meaning
// IDLE  | ready for a source word; pushes it next cycle if a target is free
// PAUSE | holding one word whose target(s) are blocked; source stalled
module ingress_dispatch
  import routing_pkg::*;
#(
  parameter bit CLASS_STEER = 1'b0,
  parameter int COUNT_W     = COUNT_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               valid_in,
  input  logic [7:0]         data_in,
  input  logic               class_in,
  output logic               ready_out,
  input  logic               flush,
  input  logic               almost_full0,
  input  logic               fifo_full0,
  input  logic               almost_full1,
  input  logic               fifo_full1,
  output logic               push0,
  output logic [WORD_W-1:0]  word0,
  output logic               push1,
  output logic [WORD_W-1:0]  word1,
  output logic               pause,
  output logic               Error,
  output logic [COUNT_W-1:0] count0,
  output logic [COUNT_W-1:0] count1
);

  state_e              state_q, state_d;
  logic                rr_q, rr_d;
  logic [WORD_W-1:0]   hold_q, hold_d;
  logic                ready_q, ready_d;
  logic                pause_q, pause_d;
  logic                push0_q, push0_d, push1_q, push1_d;
  logic [WORD_W-1:0]   word0_q, word0_d, word1_q, word1_d;
  logic                error_q, error_d;
  logic [COUNT_W-1:0]  count0_q, count0_d, count1_q, count1_d;

  logic [1:0]          blocked;
  logic [WORD_W-1:0]   in_word, push_word;
  logic                pref_class, sel, none, launch;

  assign blocked    = {almost_full1 | fifo_full1, almost_full0 | fifo_full0};
  assign in_word    = {1'b1, class_in, data_in};
  assign pref_class = (state_q == PAUSE) ? hold_q[CLASS_BIT] : class_in;

  rr_pick2 u_pick (
    .rr         (rr_q),
    .pref_class (pref_class),
    .steer_mode (CLASS_STEER),
    .blocked    (blocked),
    .sel        (sel),
    .none       (none)
  );

  // Next-state, hold register, push strobes, counters and sticky error.
  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    hold_d    = hold_q;
    push0_d   = 1'b0;
    push1_d   = 1'b0;
    word0_d   = word0_q;
    word1_d   = word1_q;
    push_word = in_word;
    launch    = 1'b0;
    case (state_q)
      IDLE: begin
        if (valid_in && ready_q) begin
          if (none) begin
            hold_d  = in_word;
            state_d = PAUSE;
          end else begin
            launch = 1'b1;
          end
        end
      end
      PAUSE: begin
        push_word = hold_q;
        // Flush wins even if a target frees up in the same cycle.
        if (flush) begin
          hold_d  = '0;
          state_d = IDLE;
        end else if (!none) begin
          launch  = 1'b1;
          hold_d  = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (launch) begin
      rr_d = !sel;
      if (sel) begin
        push1_d = 1'b1;
        word1_d = push_word;
      end else begin
        push0_d = 1'b1;
        word0_d = push_word;
      end
    end
    count0_d = push0_d ? count0_q + COUNT_W'(1) : count0_q;
    count1_d = push1_d ? count1_q + COUNT_W'(1) : count1_q;
    error_d  = error_q | (push0_q & fifo_full0) | (push1_q & fifo_full1);
    ready_d  = (state_d == IDLE);
    pause_d  = (state_d == PAUSE);
  end

  // All state and output registers; ready stays low until the first clock after reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      rr_q     <= 1'b0;
      hold_q   <= '0;
      ready_q  <= 1'b0;
      pause_q  <= 1'b0;
      push0_q  <= 1'b0;
      push1_q  <= 1'b0;
      word0_q  <= '0;
      word1_q  <= '0;
      error_q  <= 1'b0;
      count0_q <= '0;
      count1_q <= '0;
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      hold_q   <= hold_d;
      ready_q  <= ready_d;
      pause_q  <= pause_d;
      push0_q  <= push0_d;
      push1_q  <= push1_d;
      word0_q  <= word0_d;
      word1_q  <= word1_d;
      error_q  <= error_d;
      count0_q <= count0_d;
      count1_q <= count1_d;
    end
  end

  assign ready_out = ready_q;
  assign pause     = pause_q;
  assign push0     = push0_q;
  assign push1     = push1_q;
  assign word0     = word0_q;
  assign word1     = word1_q;
  assign Error     = error_q;
  assign count0    = count0_q;
  assign count1    = count1_q;

endmodule

// File: tb/tb_ingress_dispatch.sv
// Directed bench: default round-robin instance, class-steer instance, 2-bit counter instance.
module tb_ingress_dispatch;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       valid_in = 1'b0;
  logic [7:0] data_in = '0;
  logic       class_in = 1'b0;
  logic       flush = 1'b0;
  logic       almost_full0 = 1'b0, fifo_full0 = 1'b0;
  logic       almost_full1 = 1'b0, fifo_full1 = 1'b0;

  logic       d_ready, d_push0, d_push1, d_pause, d_err;
  logic [9:0] d_word0, d_word1;
  logic [7:0] d_cnt0, d_cnt1;
  logic       c_ready, c_push0, c_push1, c_pause, c_err;
  logic [9:0] c_word0, c_word1;
  logic [7:0] c_cnt0, c_cnt1;
  logic       w_ready, w_push0, w_push1, w_pause, w_err;
  logic [9:0] w_word0, w_word1;
  logic [1:0] w_cnt0, w_cnt1;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  ingress_dispatch dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .data_in(data_in), .class_in(class_in),
    .ready_out(d_ready), .flush(flush), .almost_full0(almost_full0), .fifo_full0(fifo_full0),
    .almost_full1(almost_full1), .fifo_full1(fifo_full1), .push0(d_push0), .word0(d_word0),
    .push1(d_push1), .word1(d_word1), .pause(d_pause), .Error(d_err),
    .count0(d_cnt0), .count1(d_cnt1)
  );

  ingress_dispatch #(.CLASS_STEER(1'b1)) dut_cs (
    .clk(clk), .reset(reset), .valid_in(valid_in), .data_in(data_in), .class_in(class_in),
    .ready_out(c_ready), .flush(flush), .almost_full0(almost_full0), .fifo_full0(fifo_full0),
    .almost_full1(almost_full1), .fifo_full1(fifo_full1), .push0(c_push0), .word0(c_word0),
    .push1(c_push1), .word1(c_word1), .pause(c_pause), .Error(c_err),
    .count0(c_cnt0), .count1(c_cnt1)
  );

  ingress_dispatch #(.COUNT_W(2)) dut_w2 (
    .clk(clk), .reset(reset), .valid_in(valid_in), .data_in(data_in), .class_in(class_in),
    .ready_out(w_ready), .flush(flush), .almost_full0(almost_full0), .fifo_full0(fifo_full0),
    .almost_full1(almost_full1), .fifo_full1(fifo_full1), .push0(w_push0), .word0(w_word0),
    .push1(w_push1), .word1(w_word1), .pause(w_pause), .Error(w_err),
    .count0(w_cnt0), .count1(w_cnt1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    valid_in = 0; data_in = '0; class_in = 0; flush = 0;
    almost_full0 = 0; fifo_full0 = 0; almost_full1 = 0; fifo_full1 = 0;
    reset = 0;
    tick();
    tick();
    reset = 1;
    tick();
  endtask

  task automatic test_reset();
    logic any_push;
    do_reset();
    total++;
    if (d_ready !== 1'b1) $display("FAIL reset_ready got=%b exp=1", d_ready); else passed++;
    valid_in = 1; data_in = 8'h12; class_in = 0;
    tick();
    total++;
    if ({d_push0, d_word0, d_cnt0} !== {1'b1, 10'h212, 8'd1})
      $display("FAIL pre_push got=%b/%h/%0d exp=1/212/1", d_push0, d_word0, d_cnt0);
    else passed++;
    almost_full0 = 1; almost_full1 = 1; data_in = 8'h34;
    tick();
    valid_in = 0;
    total++;
    if ({d_pause, d_ready} !== 2'b10) $display("FAIL reset_enter_pause got=%b%b exp=10", d_pause, d_ready); else passed++;
    #2 reset = 0;
    #1;
    total++;
    if ({d_push0, d_push1, d_word0, d_word1, d_pause, d_err, d_cnt0, d_cnt1, d_ready} !== '0)
      $display("FAIL reset_async_clear got=%b%b %h %h %b%b %0d %0d %b exp=all zero",
               d_push0, d_push1, d_word0, d_word1, d_pause, d_err, d_cnt0, d_cnt1, d_ready);
    else passed++;
    almost_full0 = 0; almost_full1 = 0;
    tick();
    reset = 1;
    tick();
    total++;
    if ({d_ready, d_pause} !== 2'b10) $display("FAIL reset_release got=%b%b exp=10", d_ready, d_pause); else passed++;
    any_push = 0;
    for (int i = 0; i < 4; i++) begin
      any_push |= d_push0 | d_push1;
      tick();
    end
    any_push |= d_push0 | d_push1;
    total++;
    if ({any_push, d_cnt0, d_cnt1} !== 17'd0)
      $display("FAIL reset_held_dropped got=%b/%0d/%0d exp=0/0/0", any_push, d_cnt0, d_cnt1);
    else passed++;
  endtask

  task automatic test_round_robin();
    do_reset();
    valid_in = 1; data_in = 8'hA1; class_in = 0;
    tick();
    total++;
    if ({d_push0, d_push1, d_word0} !== {2'b10, 10'h2A1})
      $display("FAIL rr_word_a got=%b%b %h exp=10 2a1", d_push0, d_push1, d_word0);
    else passed++;
    data_in = 8'hB2; class_in = 1;
    tick();
    total++;
    if ({d_push0, d_push1, d_word1} !== {2'b01, 10'h3B2})
      $display("FAIL rr_word_b got=%b%b %h exp=01 3b2", d_push0, d_push1, d_word1);
    else passed++;
    data_in = 8'hC3; class_in = 0;
    tick();
    valid_in = 0;
    total++;
    if ({d_push0, d_push1, d_word0, d_word1} !== {2'b10, 10'h2C3, 10'h3B2})
      $display("FAIL rr_word_c got=%b%b %h %h exp=10 2c3 3b2", d_push0, d_push1, d_word0, d_word1);
    else passed++;
    total++;
    if ({d_cnt0, d_cnt1} !== {8'd2, 8'd1}) $display("FAIL rr_counts got=%0d/%0d exp=2/1", d_cnt0, d_cnt1); else passed++;
    tick();
    total++;
    if ({d_push0, d_push1, d_word0} !== {2'b00, 10'h2C3})
      $display("FAIL rr_idle_hold got=%b%b %h exp=00 2c3", d_push0, d_push1, d_word0);
    else passed++;
  endtask

  task automatic test_redirect();
    do_reset();
    almost_full0 = 1;
    valid_in = 1; data_in = 8'h11; class_in = 0;
    tick();
    total++;
    if ({d_push0, d_push1, d_word1} !== {2'b01, 10'h211})
      $display("FAIL redirect_a got=%b%b %h exp=01 211", d_push0, d_push1, d_word1);
    else passed++;
    data_in = 8'h22;
    tick();
    valid_in = 0;
    total++;
    if ({d_push0, d_push1, d_word1} !== {2'b01, 10'h222})
      $display("FAIL redirect_b got=%b%b %h exp=01 222", d_push0, d_push1, d_word1);
    else passed++;
    total++;
    if ({d_cnt0, d_cnt1} !== {8'd0, 8'd2}) $display("FAIL redirect_counts got=%0d/%0d exp=0/2", d_cnt0, d_cnt1); else passed++;
    almost_full0 = 0;
  endtask

  task automatic test_pause_release();
    do_reset();
    almost_full0 = 1; almost_full1 = 1;
    valid_in = 1; data_in = 8'h55; class_in = 0;
    tick();
    valid_in = 0;
    total++;
    if ({d_pause, d_ready, d_push0, d_push1} !== 4'b1000)
      $display("FAIL pause_enter got=%b%b%b%b exp=1000", d_pause, d_ready, d_push0, d_push1);
    else passed++;
    tick();
    total++;
    if ({d_pause, d_push0, d_push1} !== 3'b100)
      $display("FAIL pause_stays got=%b%b%b exp=100", d_pause, d_push0, d_push1);
    else passed++;
    almost_full1 = 0;
    tick();
    total++;
    if ({d_push0, d_push1, d_word1, d_pause, d_ready} !== {2'b01, 10'h255, 2'b01})
      $display("FAIL pause_release got=%b%b %h %b%b exp=01 255 01", d_push0, d_push1, d_word1, d_pause, d_ready);
    else passed++;
    almost_full0 = 0;
  endtask

  task automatic test_class_flush();
    do_reset();
    almost_full1 = 1;
    valid_in = 1; data_in = 8'h7F; class_in = 1;
    tick();
    valid_in = 0; class_in = 0;
    total++;
    if ({c_pause, c_ready, c_push0, c_push1} !== 4'b1000)
      $display("FAIL class_no_redirect got=%b%b%b%b exp=1000", c_pause, c_ready, c_push0, c_push1);
    else passed++;
    flush = 1; almost_full1 = 0;
    tick();
    flush = 0;
    total++;
    if ({c_pause, c_ready, c_push0, c_push1} !== 4'b0100)
      $display("FAIL class_flush got=%b%b%b%b exp=0100", c_pause, c_ready, c_push0, c_push1);
    else passed++;
    tick();
    total++;
    if ({c_push0, c_push1, c_cnt0, c_cnt1} !== 18'd0)
      $display("FAIL class_flush_counts got=%b%b %0d %0d exp=00 0 0", c_push0, c_push1, c_cnt0, c_cnt1);
    else passed++;
    valid_in = 1; data_in = 8'h44; class_in = 1;
    tick();
    valid_in = 0;
    total++;
    if ({c_push0, c_push1, c_word1} !== {2'b01, 10'h344})
      $display("FAIL class_steer got=%b%b %h exp=01 344", c_push0, c_push1, c_word1);
    else passed++;
  endtask

  task automatic test_wrap_error();
    do_reset();
    almost_full1 = 1;
    valid_in = 1; class_in = 0;
    for (int i = 0; i < 5; i++) begin
      data_in = 8'(i + 1);
      tick();
    end
    valid_in = 0;
    total++;
    if ({w_push0, w_cnt0, w_word0} !== {1'b1, 2'd1, 10'h205})
      $display("FAIL wrap_count got=%b %0d %h exp=1 1 205", w_push0, w_cnt0, w_word0);
    else passed++;
    total++;
    if (w_err !== 1'b0) $display("FAIL error_before got=%b exp=0", w_err); else passed++;
    fifo_full0 = 1;
    tick();
    total++;
    if (w_err !== 1'b1) $display("FAIL error_set got=%b exp=1", w_err); else passed++;
    fifo_full0 = 0; almost_full1 = 0;
    tick();
    tick();
    total++;
    if (w_err !== 1'b1) $display("FAIL error_sticky got=%b exp=1", w_err); else passed++;
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_redirect();
    test_pause_release();
    test_class_flush();
    test_wrap_error();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
